// File: rtl/trace_packet_decoder.sv
// trace_packet_decoder
//
// Receiving end of the RAM tracer packet stream. Rebuilds absolute RAM bus
// events (address, data, byte lanes, direction, burst word index, cycle time)
// from 2-bit type / 23-bit payload packets and queues them in an event FIFO
// with a valid/ready handshake.
//
// Optional build macro: TRACE_DECODE_ERRCHK_EN enables protocol checking
// (data packet before any address, or direction change inside a burst).
// When undefined, proto_err is tied low.
//
// Ports:
//   mclk, reset          clock, synchronous active-high reset
//   pkt_strobe           one packet per asserted cycle
//   pkt_type             00 addr, 01 read word, 10 write word, 11 timestamp
//   pkt_payload          packet payload
//   ev_valid / ev_ready  event FIFO handshake (head of FIFO)
//   ev_write, ev_addr, ev_data, ev_ublb, ev_time, ev_index  head event fields
//   overflow             sticky, an event was dropped on a full FIFO
//   drop_count           dropped events, saturating
//   proto_err            sticky protocol-error flag
module trace_packet_decoder #(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic        mclk,
    input  logic        reset,
    input  logic        pkt_strobe,
    input  logic [1:0]  pkt_type,
    input  logic [22:0] pkt_payload,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic        ev_write,
    output logic [22:0] ev_addr,
    output logic [15:0] ev_data,
    output logic [1:0]  ev_ublb,
    output logic [31:0] ev_time,
    output logic [7:0]  ev_index,
    output logic        overflow,
    output logic [15:0] drop_count,
    output logic        proto_err
);

    typedef struct packed {
        logic        write;
        logic [22:0] addr;
        logic [15:0] data;
        logic [1:0]  ublb;
        logic [31:0] cyc_time;
        logic [7:0]  index;
    } event_t;

    localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

    logic [22:0]      cur_addr;
    logic [31:0]      cyc;
    logic [7:0]       index;

    event_t           mem [FIFO_DEPTH];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;

    logic             is_data;
    logic             pkt_write;
    logic [31:0]      t_next;
    logic             fifo_full;
    logic             pop;
    logic             push_ok;
    logic             drop;
    event_t           push_ev;
    event_t           head;

    assign pkt_write = (pkt_type == 2'b10);
    assign is_data   = pkt_strobe && !reset && (pkt_type == 2'b01 || pkt_type == 2'b10);
    assign t_next    = cyc + {27'd0, pkt_payload[22:18]};

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign fifo_full = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                       (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign ev_valid  = (wr_ptr != rd_ptr);
    assign pop       = ev_valid && ev_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push_ok   = is_data && (!fifo_full || pop);
    assign drop      = is_data && !push_ok;

    always_comb begin
        push_ev          = '0;
        push_ev.write    = pkt_write;
        push_ev.addr     = cur_addr;
        push_ev.data     = pkt_payload[15:0];
        push_ev.ublb     = pkt_payload[17:16];
        push_ev.cyc_time = t_next;
        push_ev.index    = index;
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            cur_addr   <= '0;
            cyc        <= '0;
            index      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (pkt_strobe) begin
                unique case (pkt_type)
                    2'b00: begin
                        cur_addr <= pkt_payload;
                        index    <= '0;
                    end
                    2'b11: cyc <= cyc + {9'd0, pkt_payload};
                    default: begin
                        cyc      <= t_next;
                        cur_addr <= cur_addr + 23'd1;
                        if (index != 8'hFF)
                            index <= index + 8'd1;
                    end
                endcase
            end
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF)
                    drop_count <= drop_count + 16'd1;
            end
        end
    end

    // Storage kept out of the reset branch so it can map onto distributed RAM.
    always_ff @(posedge mclk) begin
        if (push_ok)
            mem[wr_ptr[FIFO_AW-1:0]] <= push_ev;
    end

    assign head     = mem[rd_ptr[FIFO_AW-1:0]];
    assign ev_write = head.write;
    assign ev_addr  = head.addr;
    assign ev_data  = head.data;
    assign ev_ublb  = head.ublb;
    assign ev_time  = head.cyc_time;
    assign ev_index = head.index;

`ifdef TRACE_DECODE_ERRCHK_EN
    logic have_addr;
    logic burst_dir;
    logic burst_dir_vld;
    logic proto_err_q;

    always_ff @(posedge mclk) begin
        if (reset) begin
            have_addr     <= 1'b0;
            burst_dir     <= 1'b0;
            burst_dir_vld <= 1'b0;
            proto_err_q   <= 1'b0;
        end else if (pkt_strobe) begin
            if (pkt_type == 2'b00) begin
                have_addr     <= 1'b1;
                burst_dir_vld <= 1'b0;
            end else if (is_data) begin
                if (!have_addr) begin
                    proto_err_q <= 1'b1;
                end else if (!burst_dir_vld) begin
                    // First data word after an address fixes the burst direction.
                    burst_dir     <= pkt_write;
                    burst_dir_vld <= 1'b1;
                end else if (pkt_write != burst_dir) begin
                    proto_err_q <= 1'b1;
                end
            end
        end
    end

    assign proto_err = proto_err_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_trace_packet_decoder.sv
module tb_trace_packet_decoder;

    localparam int FIFO_DEPTH = 16;
    localparam int FIFO_AW    = 4;

`ifdef TRACE_DECODE_ERRCHK_EN
    localparam logic ERRCHK = 1'b1;
`else
    localparam logic ERRCHK = 1'b0;
`endif

    localparam logic [31:0] TBASE = 32'h0080001E;

    logic        mclk = 1'b0;
    logic        reset = 1'b1;
    logic        pkt_strobe = 1'b0;
    logic [1:0]  pkt_type = 2'b00;
    logic [22:0] pkt_payload = '0;
    logic        ev_ready = 1'b0;
    logic        ev_valid;
    logic        ev_write;
    logic [22:0] ev_addr;
    logic [15:0] ev_data;
    logic [1:0]  ev_ublb;
    logic [31:0] ev_time;
    logic [7:0]  ev_index;
    logic        overflow;
    logic [15:0] drop_count;
    logic        proto_err;

    int checks = 0;
    int errors = 0;
    logic [81:0] sb_q[$];

    trace_packet_decoder #(.FIFO_DEPTH(FIFO_DEPTH), .FIFO_AW(FIFO_AW)) dut (
        .mclk(mclk), .reset(reset), .pkt_strobe(pkt_strobe), .pkt_type(pkt_type),
        .pkt_payload(pkt_payload), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_write(ev_write), .ev_addr(ev_addr), .ev_data(ev_data), .ev_ublb(ev_ublb),
        .ev_time(ev_time), .ev_index(ev_index), .overflow(overflow),
        .drop_count(drop_count), .proto_err(proto_err)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input string tag, input logic [81:0] obs, input logic [81:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [81:0] head_ev();
        return {ev_write, ev_addr, ev_data, ev_ublb, ev_time, ev_index};
    endfunction

    task automatic pkt(input logic [1:0] t, input logic [22:0] p);
        pkt_strobe  = 1'b1;
        pkt_type    = t;
        pkt_payload = p;
        @(negedge mclk);
        pkt_strobe  = 1'b0;
    endtask

    task automatic data_pkt(input logic wr, input logic [4:0] ts, input logic [1:0] ub,
                            input logic [15:0] d, input logic [22:0] ea,
                            input logic [31:0] et, input logic [7:0] ei, input logic exp_push);
        if (exp_push)
            sb_q.push_back({wr, ea, d, ub, et, ei});
        pkt(wr ? 2'b10 : 2'b01, {ts, ub, d});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge mclk);
        reset = 1'b0;
        sb_q.delete();
    endtask

    task automatic drain(input int budget);
        ev_ready = 1'b1;
        for (int i = 0; i < budget && sb_q.size() > 0; i++) begin
            if (ev_valid)
                chk("event", head_ev(), sb_q.pop_front());
            @(negedge mclk);
        end
        ev_ready = 1'b0;
        chk("drain_done", 82'(sb_q.size()), 82'd0);
        chk("valid_after_drain", 82'(ev_valid), 82'd0);
    endtask

    initial begin
        reset = 1'b1;
        @(negedge mclk);
        @(negedge mclk);
        reset = 1'b0;
        chk("rst_valid", 82'(ev_valid), 82'd0);
        chk("rst_overflow", 82'(overflow), 82'd0);
        chk("rst_drop_count", 82'(drop_count), 82'd0);
        chk("rst_proto_err", 82'(proto_err), 82'd0);

        // Write burst at 0x100
        pkt(2'b00, 23'h000100);
        chk("addr_no_event", 82'(ev_valid), 82'd0);
        data_pkt(1'b1, 5'd0, 2'b11, 16'hA0A0, 23'h100, 32'd0, 8'd0, 1'b1);
        chk("valid_latency", 82'(ev_valid), 82'd1);
        data_pkt(1'b1, 5'd1, 2'b11, 16'hA1A1, 23'h101, 32'd1, 8'd1, 1'b1);
        data_pkt(1'b1, 5'd2, 2'b11, 16'hA2A2, 23'h102, 32'd3, 8'd2, 1'b1);
        chk("burst_proto_err", 82'(proto_err), 82'd0);
        drain(20);

        // Timestamp then read with ts5=31
        do_reset();
        pkt(2'b00, 23'h000200);
        pkt(2'b11, 23'h7FFFFF);
        chk("ts_no_event", 82'(ev_valid), 82'd0);
        data_pkt(1'b0, 5'd31, 2'b01, 16'hBEEF, 23'h200, TBASE, 8'd0, 1'b1);
        drain(20);

        // Address wrap
        pkt(2'b00, 23'h7FFFFF);
        data_pkt(1'b0, 5'd0, 2'b10, 16'h0001, 23'h7FFFFF, TBASE, 8'd0, 1'b1);
        data_pkt(1'b0, 5'd0, 2'b10, 16'h0002, 23'h000000, TBASE, 8'd1, 1'b1);
        chk("wrap_proto_err", 82'(proto_err), 82'd0);
        drain(20);

        // Overflow: 18 writes into a 16-deep FIFO with no consumer
        pkt(2'b00, 23'h000010);
        for (int i = 0; i < 18; i++)
            data_pkt(1'b1, 5'd1, 2'b11, 16'(32'h5000 + i), 23'(32'h10 + i),
                     TBASE + 32'(i + 1), 8'(i), i < FIFO_DEPTH);
        chk("ovf_flag", 82'(overflow), 82'd1);
        chk("ovf_drop_count", 82'(drop_count), 82'd2);
        chk("ovf_valid", 82'(ev_valid), 82'd1);
        // Push while full with a simultaneous pop must not drop
        chk("event", head_ev(), sb_q.pop_front());
        ev_ready = 1'b1;
        data_pkt(1'b1, 5'd1, 2'b11, 16'h5012, 23'h22, TBASE + 32'd19, 8'd18, 1'b1);
        ev_ready = 1'b0;
        chk("full_pushpop_drop_count", 82'(drop_count), 82'd2);
        drain(40);
        chk("ovf_sticky", 82'(overflow), 82'd1);

        // Data before any address
        do_reset();
        data_pkt(1'b0, 5'd2, 2'b01, 16'h1234, 23'h0, 32'd2, 8'd0, 1'b1);
        chk("noaddr_proto_err", 82'(proto_err), 82'(ERRCHK));
        drain(20);

        // Direction change within a burst
        do_reset();
        pkt(2'b00, 23'h000040);
        data_pkt(1'b1, 5'd0, 2'b11, 16'h4444, 23'h40, 32'd0, 8'd0, 1'b1);
        chk("dir_first_proto_err", 82'(proto_err), 82'd0);
        data_pkt(1'b0, 5'd0, 2'b11, 16'h5555, 23'h41, 32'd0, 8'd1, 1'b1);
        chk("dir_change_proto_err", 82'(proto_err), 82'(ERRCHK));
        drain(20);

        // Reset mid-burst, with a packet strobed during the reset cycle
        do_reset();
        pkt(2'b00, 23'h000300);
        data_pkt(1'b1, 5'd0, 2'b11, 16'h6666, 23'h300, 32'd0, 8'd0, 1'b1);
        data_pkt(1'b1, 5'd1, 2'b11, 16'h7777, 23'h301, 32'd1, 8'd1, 1'b1);
        reset       = 1'b1;
        pkt_strobe  = 1'b1;
        pkt_type    = 2'b10;
        pkt_payload = {5'd3, 2'b11, 16'h9999};
        @(negedge mclk);
        reset      = 1'b0;
        pkt_strobe = 1'b0;
        sb_q.delete();
        chk("midrst_valid", 82'(ev_valid), 82'd0);
        chk("midrst_proto_err", 82'(proto_err), 82'd0);
        chk("midrst_overflow", 82'(overflow), 82'd0);
        data_pkt(1'b1, 5'd5, 2'b11, 16'h8888, 23'h0, 32'd5, 8'd0, 1'b1);
        chk("postrst_proto_err", 82'(proto_err), 82'(ERRCHK));
        drain(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trace_packet_decoder.md
# trace_packet_decoder

Receiving end of the RAM tracer packet stream. The block takes the decoded 2-bit type and 23-bit payload of each trace packet and rebuilds absolute RAM bus events: address, data, byte lanes, direction, word index within the burst, and cycle time. Decoded events go into a small output FIFO with a valid/ready handshake. The block serves on-chip loopback self-test of the tracing state machine, and a future trigger/replay engine on the FPGA.

## Interface
- `FIFO_DEPTH`, 16: event FIFO entries; power of two, ≥2
- `FIFO_AW`, 4: log2(`FIFO_DEPTH`)
- `mclk` in 1: the block's only clock; all logic on its rising edge
- `reset` in 1: synchronous, active-high
- `pkt_strobe` in 1: one packet per asserted cycle; no backpressure
- `pkt_type` in 2: 00 address, 01 read word, 10 write word, 11 timestamp
- `pkt_payload` in 23: packet payload
- `ev_valid` out 1: FIFO head holds an event
- `ev_ready` in 1: consumer accepts the head
- `ev_write` out 1: 1 = write word, 0 = read word
- `ev_addr` out 23: word address of this data word
- `ev_data` out 16: data word
- `ev_ublb` out 2: byte-lane field, copied from the packet
- `ev_time` out 32: absolute decoded cycle count
- `ev_index` out 8: word index within burst, saturating
- `overflow` out 1: sticky; an event was dropped
- `drop_count` out 16: dropped events, saturating at 16'hFFFF
- `proto_err` out 1: sticky protocol-error flag (see Configuration)

## Operation
- Registers: `cur_addr`[22:0], `cyc`[31:0], `index`[7:0], `have_addr`, `burst_dir`.
- Address packet (00):
  - `cur_addr` ← payload
  - `index` ← 0
  - `have_addr` ← 1
  - `cyc` unchanged
  - no event pushed
- Timestamp packet (11): `cyc` ← `cyc` + zero-extended payload, modulo 2^32; no event pushed.
- Data packet (01/10): payload = {ts5[4:0], ublb[1:0], data[15:0]}.
  - `t` = `cyc` + ts5; `cyc` ← `t`
  - Push {dir, `cur_addr`, data, ublb, `t`, `index`}.
  - Then `cur_addr` ← `cur_addr` + 1, wrapping modulo 2^23.
  - Then `index` ← `index` + 1, saturating at 255.
- FIFO:
  - Push is accepted if not full, or if full and a pop happens in the same cycle.
  - Otherwise the event is dropped: `overflow` ← 1 and `drop_count` increments.
  - Decoder state (`cur_addr`, `cyc`, `index`) advances whether or not the push succeeds.
- Pop occurs when `ev_valid` && `ev_ready`.
- `ev_*` outputs present the FIFO head. Their value is don't-care while `ev_valid`=0.
- Reset values:
  - `ev_valid` 0, `overflow` 0, `drop_count` 0, `proto_err` 0
  - `cur_addr` 0, `cyc` 0, `index` 0, `have_addr` 0, FIFO empty
- Reset asserted mid-stream clears all state. Packets in the reset cycle are ignored.

## Timing
- Data packet strobed at cycle N → `ev_valid`=1 at cycle N+1, provided the FIFO was empty.
- Back-to-back packets are accepted every cycle. Sustained rate is 1 event/cycle if `ev_ready` is held high.
- An address packet at N affects the `ev_addr` of a data packet strobed at N+1.
- `overflow` and `drop_count` update at N+1 for a drop at N.
- `ev_*` hold stable while `ev_valid`=1 and `ev_ready`=0.

## Configuration
- `TRACE_DECODE_ERRCHK_EN` defined: `proto_err` is set on either of these conditions:
  - a data packet while `have_addr`=0;
  - a data packet whose direction differs from `burst_dir`. `burst_dir` is latched from the first data packet after each address packet.
- The offending event is still pushed.
- Not defined: `proto_err` is tied to 0, and the `have_addr`/`burst_dir` tracking is removed.

## Test plan
- Reset, then strobe addr 0x000100, then three writes (ts5=0,1,2; data A0A0/A1A1/A2A2; ublb=11) → events at addr 100/101/102, time 0/1/3, index 0/1/2, `ev_write`=1.
- Timestamp payload 0x7FFFFF, then read with ts5=31 → `ev_time`=0x0080001E; `ev_write`=0.
- Addr 0x7FFFFF, then 2 reads → `ev_addr` 7FFFFF then 000000.
- Hold `ev_ready`=0 and push 18 data packets with `FIFO_DEPTH`=16 → 16 events retained, `overflow`=1, `drop_count`=2. Simultaneous push+pop when full → no drop.
- With `TRACE_DECODE_ERRCHK_EN`: data packet before any address → `proto_err`=1. A read following a write in the same burst also → 1. Without the macro, both cases keep `proto_err` at 0.
- Assert `reset` for 1 cycle mid-burst, then send a data packet → `proto_err` 1 if the macro is defined, `ev_addr`=0, `ev_time`=ts5, `index`=0.
